// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a back-pressure stall counter.
// Define PIPE_SKID_EN for the 2-entry skid build (registered in_ready); otherwise 1-entry.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  logic [WIDTH-1:0] skid_q;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic             ready_q;
  logic [WIDTH-1:0] main_q;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef PIPE_SKID_EN
      ready_q <= (state_d != FULL);
`else
      ready_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (in_xfer) state_d = BUSY;
      BUSY: begin
        if (out_xfer && !in_xfer) state_d = EMPTY;
`ifdef PIPE_SKID_EN
        else if (in_xfer && !out_xfer) state_d = FULL;
`endif
      end
`ifdef PIPE_SKID_EN
      FULL: if (out_xfer) state_d = BUSY;
`endif
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    unique case (state_q)
      BUSY:    occupancy = 2'd1;
`ifdef PIPE_SKID_EN
      FULL:    occupancy = 2'd2;
`endif
      default: occupancy = 2'd0;
    endcase
`ifdef PIPE_SKID_EN
    in_ready = ready_q && !flush;
`else
    // ready_q only gates the first cycle after reset; the rest is pass-through
    in_ready = ready_q && !flush && (state_q == EMPTY || out_ready);
`endif
  end

  always_ff @(posedge clk) begin
    if (in_xfer && (!out_valid || out_xfer)) main_q <= in_data;
`ifdef PIPE_SKID_EN
    if (state_q == FULL && out_xfer) main_q <= skid_q;
    if (state_q == BUSY && in_xfer && !out_xfer) skid_q <= in_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
